// File: rtl/mas_pkg.sv
// Shared types and sizing for the MAS Booth multiplier datapath.
package mas_pkg;

  localparam int DATA_W_DFLT = 32;

  function automatic int num_pp(input int data_w);
    return data_w / 2;
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  typedef logic signed [DATA_W_DFLT:0]         pp_t;
  typedef logic        [2*DATA_W_DFLT-1:0]     prod_t;
  typedef logic [$clog2(num_pp(DATA_W_DFLT))-1:0] cnt_t;

endpackage

// File: rtl/mas_pp_shift_add.sv
// Conditionally negates one Booth partial product, weights it by 4^cnt and
// adds it to the running sum.
module mas_pp_shift_add #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W:0]     pp_mag,
  input  logic                pp_neg,
  input  logic [CNT_W-1:0]    cnt,
  output logic [2*DATA_W-1:0] sum
);

  logic [DATA_W+1:0]   ext;
  logic [DATA_W+1:0]   term_n;
  logic [2*DATA_W-1:0] term;

  // One guard bit so that negating 2M at the most negative M stays in range.
  always_comb begin
    ext    = {pp_mag[DATA_W], pp_mag};
    term_n = pp_neg ? (~ext + 1'b1) : ext;
    term   = {{(DATA_W-2){term_n[DATA_W+1]}}, term_n};
    sum    = acc + (term << {cnt, 1'b0});
  end

endmodule

// File: rtl/mas_booth_pp_accumulator.sv
// Radix-4 Booth partial-product accumulator with valid/ready result port.
//   state | meaning
//   ACCUM | accepting beats, summing into acc
//   DONE  | product held on res until downstream takes it
module mas_booth_pp_accumulator
  import mas_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pp_valid,
  output logic                pp_ready,
  input  logic [DATA_W:0]     pp_mag,
  input  logic                pp_neg,
  input  logic                pp_last,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*DATA_W-1:0] res,
  output logic                frame_err
);

  localparam int NUM_PP = num_pp(DATA_W);
  localparam int CNT_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                ferr_q, ferr_d;
  logic [2*DATA_W-1:0] sum;
  logic                at_top;

  mas_pp_shift_add #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift_add (
    .acc    (acc_q),
    .pp_mag (pp_mag),
    .pp_neg (pp_neg),
    .cnt    (cnt_q),
    .sum    (sum)
  );

  assign at_top = (cnt_q == CNT_W'(NUM_PP - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ferr_d  = ferr_q;
    case (state_q)
      ACCUM: begin
        if (pp_valid) begin
          acc_d = sum;
          if (pp_last || at_top) begin
            // Early pp_last and a missing pp_last on the top digit are both errors.
            state_d = DONE;
            res_d   = sum;
            ferr_d  = pp_last ^ at_top;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ferr_q  <= ferr_d;
    end
  end

  assign pp_ready  = (state_q == ACCUM);
  assign res_valid = (state_q == DONE);
  assign res       = res_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_mas_booth_pp_accumulator.sv
// Directed bench for mas_booth_pp_accumulator with hand-computed products.
module tb_mas_booth_pp_accumulator;

  logic        clk;
  logic        rst_n;
  logic        pp_valid;
  logic        pp_ready;
  logic [32:0] pp_mag;
  logic        pp_neg;
  logic        pp_last;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;

  mas_booth_pp_accumulator #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp_mag    (pp_mag),
    .pp_neg    (pp_neg),
    .pp_last   (pp_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [32:0] m, input logic n, input logic l);
    pp_valid = 1'b1;
    pp_mag   = m;
    pp_neg   = n;
    pp_last  = l;
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
    pp_mag   = 'x;
    pp_neg   = 1'bx;
    pp_last  = 1'bx;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [63:0] exp_res, input logic exp_err);
    chk({tag, "_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_err"}, 64'(frame_err), 64'(exp_err));
    chk({tag, "_ppready"}, 64'(pp_ready), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ppready"}, 64'(pp_ready), 64'd1);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res"}, res, 64'd0);
    chk({tag, "_err"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    pp_valid  = 1'b0;
    pp_mag    = '0;
    pp_neg    = 1'b0;
    pp_last   = 1'b0;
    res_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 3 * 5: Booth digits of 5 are {1, 1}
    beat(33'd3, 1'b0, 1'b0);
    beat(33'd3, 1'b0, 1'b0);
    for (int i = 2; i < 15; i++) beat(33'd0, 1'b0, 1'b0);
    chk("m3x5_pre_valid", 64'(res_valid), 64'd0);
    chk("m3x5_pre_ppready", 64'(pp_ready), 64'd1);
    beat(33'd0, 1'b0, 1'b1);
    check_done("m3x5", 64'd15, 1'b0);
    accept();

    // -1 * -1: digit0 = -1 applied to M = -1
    beat(33'h1_FFFF_FFFF, 1'b1, 1'b0);
    for (int i = 1; i < 15; i++) beat(33'd0, 1'b0, 1'b0);
    beat(33'd0, 1'b0, 1'b1);
    check_done("m1x1", 64'd1, 1'b0);
    accept();

    // -(2 * -2^31) in a single early-ended beat
    beat(33'h1_0000_0000, 1'b1, 1'b1);
    check_done("neg2m", 64'h0000_0001_0000_0000, 1'b1);
    accept();

    // Backpressure on a full frame of ones: sum 4^i, i=0..15
    for (int i = 0; i < 15; i++) beat(33'd1, 1'b0, 1'b0);
    beat(33'd1, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check_done("hold", 64'h0000_0000_5555_5555, 1'b0);
      idle(1);
    end
    accept();
    chk("post_accept_ppready", 64'(pp_ready), 64'd1);
    chk("post_accept_valid", 64'(res_valid), 64'd0);

    // Early end on beat 3
    for (int i = 0; i < 3; i++) beat(33'd1, 1'b0, 1'b0);
    beat(33'd1, 1'b0, 1'b1);
    check_done("early", 64'd85, 1'b1);
    accept();

    // Missing pp_last: forced end after 16 beats of 2
    for (int i = 0; i < 16; i++) beat(33'd2, 1'b0, 1'b0);
    check_done("forced", 64'h0000_0000_AAAA_AAAA, 1'b1);
    accept();

    // Stall: 7 - 5*4 = -13 with a 3-cycle gap
    beat(33'd7, 1'b0, 1'b0);
    beat(33'd5, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      idle(1);
      chk("stall_valid", 64'(res_valid), 64'd0);
      chk("stall_ppready", 64'(pp_ready), 64'd1);
    end
    for (int i = 2; i < 15; i++) beat(33'd0, 1'b0, 1'b0);
    beat(33'd0, 1'b0, 1'b1);
    check_done("stall", 64'hFFFF_FFFF_FFFF_FFF3, 1'b0);
    accept();

    // Reset mid-frame after beat 7
    for (int i = 0; i < 8; i++) beat(33'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1 + (-2 << 30): exercises the top digit weight and clean restart
    beat(33'd1, 1'b0, 1'b0);
    for (int i = 1; i < 15; i++) beat(33'd0, 1'b0, 1'b0);
    beat(33'h1_FFFF_FFFE, 1'b0, 1'b1);
    check_done("after_reset", 64'hFFFF_FFFF_8000_0001, 1'b0);
    accept();
    chk("final_ppready", 64'(pp_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
